// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter: store to BASE_ADDR queues a byte in a
// FIFO, BASE_ADDR+4 reads status and clears the sticky overflow flag on write.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'd4;
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  state_e        state_q;
  logic [15:0]   baud_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic          tx_q;

  logic wr_hit, st_hit, full, empty, push, drop, pop, baud_last;
  logic [15:0] count_ext;

  always_comb begin
    wr_hit    = we && (addr == BASE_ADDR);
    st_hit    = we && (addr == STAT_ADDR);
    full      = (count_q == CW'(FIFO_DEPTH));
    empty     = (count_q == '0);
    // Full is judged before the edge, so a simultaneous pop never rescues a push.
    push      = wr_hit && !full;
    drop      = wr_hit && full;
    pop       = (state_q == IDLE) && !empty;
    baud_last = (baud_q == BAUD_LAST);

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    ovf_d = ovf_q;
    if (drop)        ovf_d = 1'b1;
    else if (st_hit) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Serialiser; tx is registered so each bit lasts exactly CLKS_PER_BIT cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          baud_q <= '0;
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
            state_q <= START;
            tx_q    <= 1'b0;
          end
        end
        START: begin
          if (baud_last) begin
            baud_q  <= '0;
            idx_q   <= '0;
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_q <= '0;
            if (idx_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              idx_q <= idx_q + 3'd1;
              tx_q  <= shift_q[idx_q + 3'd1];
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_q  <= '0;
            state_q <= IDLE;
            tx_q    <= 1'b1;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          baud_q  <= '0;
        end
      endcase
    end
  end

  always_comb begin
    count_ext = 16'(count_q);
    rdata     = '0;
    if (addr == STAT_ADDR)
      rdata = {16'h0000, count_ext[7:0], 4'h0, ovf_q, empty, full, (state_q != IDLE)};
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=8): frame shape,
// back-to-back spacing, FIFO full/overflow, reset abort and address decode.
module tb_uart_tx;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] STAT = BASE + 32'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tx;
  logic        busy;

  int n_checks = 0;
  int n_err    = 0;

  uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8), .BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .tx    (tx),
    .busy  (busy)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; leaves the bench at a negedge with the DUT reset.
  task automatic do_reset();
    rst = 1'b1; we = 1'b1; addr = BASE; wdata = 32'h77;
    repeat (2) @(negedge clk);
    rst = 1'b0; we = 1'b0; addr = STAT; wdata = '0;
    #1;
  endtask

  task automatic write(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    we = 1'b0; addr = STAT;
    #1;
  endtask

  // Waits (bounded) for a start bit, then samples every cycle of the frame.
  // Returns on the negedge of the last stop-bit cycle.
  task automatic get_frame(output logic [7:0] data, output int idle, output logic shape_ok);
    logic s, first;
    idle = 0; shape_ok = 1'b1; data = '0; first = 1'b0;
    @(negedge clk);
    while (tx === 1'b1 && idle < 200) begin
      idle++;
      @(negedge clk);
    end
    if (tx !== 1'b0) begin
      shape_ok = 1'b0;
      return;
    end
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 4; c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk);
        s = tx;
        if (c == 0) first = s;
        else if (s !== first) shape_ok = 1'b0;
        if (b == 0 && s !== 1'b0) shape_ok = 1'b0;
        if (b == 9 && s !== 1'b1) shape_ok = 1'b0;
        if (b >= 1 && b <= 8 && c == 0) data[b-1] = s;
      end
    end
  endtask

  logic [7:0] rx_data;
  int         rx_idle;
  logic       rx_ok;
  logic       line_high;

  initial begin
    rst = 1'b1; we = 1'b0; addr = STAT; wdata = '0;
    @(negedge clk);
    do_reset();
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_status", rdata, 32'h0000_0004);

    // Single frame 8'hA5; status shows the queued byte before the pop edge.
    write(BASE, 32'hA5);
    chk("a5_pre_pop_tx", 32'(tx), 32'd1);
    chk("a5_pre_pop_status", rdata, 32'h0000_0100);
    get_frame(rx_data, rx_idle, rx_ok);
    chk("a5_latency", 32'(rx_idle), 32'd0);
    chk("a5_shape", 32'(rx_ok), 32'd1);
    chk("a5_data", 32'(rx_data), 32'hA5);
    chk("a5_busy_in_stop", 32'(busy), 32'd1);
    @(negedge clk); #1;
    chk("a5_busy_after", 32'(busy), 32'd0);
    chk("a5_status_after", rdata, 32'h0000_0004);

    // Three consecutive writes; receiver runs alongside.
    fork
      begin
        we = 1'b1; addr = BASE; wdata = 32'h41;
        @(negedge clk); wdata = 32'h42;
        @(negedge clk); wdata = 32'h43;
        @(negedge clk); we = 1'b0; addr = STAT;
        #1;
        chk("abc_status_after_writes", rdata, 32'h0000_0201);
      end
      begin
        logic [7:0] exp_b [3];
        logic [31:0] exp_s [3];
        exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
        exp_s[0] = 32'h0000_0201; exp_s[1] = 32'h0000_0101; exp_s[2] = 32'h0000_0005;
        for (int f = 0; f < 3; f++) begin
          get_frame(rx_data, rx_idle, rx_ok);
          #1;
          chk($sformatf("abc_idle%0d", f), 32'(rx_idle), 32'd1);
          chk($sformatf("abc_shape%0d", f), 32'(rx_ok), 32'd1);
          chk($sformatf("abc_data%0d", f), 32'(rx_data), 32'(exp_b[f]));
          chk($sformatf("abc_status%0d", f), rdata, exp_s[f]);
        end
      end
    join
    @(negedge clk); #1;
    chk("abc_busy_after", 32'(busy), 32'd0);

    // Ten writes while the first frame is sending: 9 accepted, 10th dropped.
    for (int i = 0; i < 10; i++) begin
      we = 1'b1; addr = BASE; wdata = 32'h10 + 32'(i);
      @(negedge clk);
    end
    we = 1'b0;
    addr = BASE; #1;
    chk("full_read_base", rdata, 32'h0);
    addr = BASE + 32'd8; #1;
    chk("full_read_base8", rdata, 32'h0);
    addr = STAT; #1;
    chk("full_status_ovf", rdata, 32'h0000_080B);
    we = 1'b1; addr = STAT; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    we = 1'b0; #1;
    chk("full_status_cleared", rdata, 32'h0000_0803);
    // First frame's successor is popped on the 43rd edge after the first write.
    repeat (31) @(negedge clk);
    we = 1'b1; addr = BASE; wdata = 32'h99;
    @(negedge clk);
    we = 1'b0; addr = STAT; #1;
    chk("full_push_on_pop", rdata, 32'h0000_0709);
    chk("full_busy", 32'(busy), 32'd1);

    // Reset during data bit 3 of 8'hFF with two bytes queued.
    do_reset();
    chk("rst2_status", rdata, 32'h0000_0004);
    we = 1'b1; addr = BASE; wdata = 32'hFF;
    @(negedge clk); wdata = 32'h01;
    @(negedge clk); wdata = 32'h02;
    @(negedge clk); we = 1'b0; addr = STAT;
    repeat (16) @(negedge clk);
    #1;
    chk("ff_mid_status", rdata, 32'h0000_0201);
    chk("ff_mid_tx", 32'(tx), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; #1;
    chk("abort_tx", 32'(tx), 32'd1);
    chk("abort_status", rdata, 32'h0000_0004);
    chk("abort_busy", 32'(busy), 32'd0);
    line_high = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) line_high = 1'b0;
    end
    chk("abort_no_frames", 32'(line_high), 32'd1);

    // Writes to an unmapped address leave the FIFO alone.
    write(BASE + 32'd8, 32'h55);
    chk("unmapped_status", rdata, 32'h0000_0004);
    chk("unmapped_busy", 32'(busy), 32'd0);
    addr = BASE + 32'd8; #1;
    chk("unmapped_read", rdata, 32'h0);
    repeat (3) @(negedge clk);
    chk("unmapped_tx", 32'(tx), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
